// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC datapath: adder tree widths, tag bundle and accumulator type.
package mac_pkg;

  localparam int unsigned IN_WIDTH     = 38;
  localparam int unsigned ACC_WIDTH    = 48;
  localparam int unsigned OUT_WIDTH    = 16;
  localparam int unsigned TREE_LATENCY = 6;
  localparam int unsigned SHIFT_WIDTH  = 6;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } psum_tag_t;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/psum_out_fifo.sv
// Two-entry result buffer with valid/ready drain; a push into a full buffer without a
// simultaneous pop is dropped and flagged on o_drop.
module psum_out_fifo #(
  parameter int unsigned WIDTH = mac_pkg::OUT_WIDTH
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_last;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign o_empty = (r_count == 2'd0);
  assign w_full  = (r_count == 2'd2);
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign w_wr    = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;
  assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_last   <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Re-aligns beat tags with the adder tree sum, accumulates partial sums across beats and
// requantises (round half up, arithmetic shift, saturate) the total into a 2-entry output buffer.
module psum_accumulator #(
  parameter int unsigned IN_WIDTH     = mac_pkg::IN_WIDTH,
  parameter int unsigned ACC_WIDTH    = mac_pkg::ACC_WIDTH,
  parameter int unsigned OUT_WIDTH    = mac_pkg::OUT_WIDTH,
  parameter int unsigned TREE_LATENCY = mac_pkg::TREE_LATENCY,
  parameter int unsigned SHIFT_WIDTH  = mac_pkg::SHIFT_WIDTH
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        tag_valid_in,
  input  logic                        tag_first_in,
  input  logic                        tag_last_in,
  input  logic signed [IN_WIDTH-1:0]  sum_in,
  input  logic [SHIFT_WIDTH-1:0]      shift_in,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sat_pulse,
  output logic                        overflow_err
);

  import mac_pkg::*;

  localparam logic signed [ACC_WIDTH-1:0] SatMax =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  psum_tag_t r_tag_pipe [TREE_LATENCY];
  psum_tag_t w_dtag;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_sext;
  logic signed [ACC_WIDTH-1:0] w_total;
  logic signed [ACC_WIDTH-1:0] w_half;
  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic signed [ACC_WIDTH-1:0] w_round;
  logic                        w_round_bit;
  logic                        w_clamp_hi;
  logic                        w_clamp_lo;
  logic [OUT_WIDTH-1:0]        w_res;
  logic                        w_push;
  logic                        w_empty;
  logic                        w_drop;
  logic [OUT_WIDTH-1:0]        w_out;

  logic r_sat;
  logic r_ovf;

  // Tag delay line matching the adder tree depth.
  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      for (int i = 0; i < TREE_LATENCY; i++) begin
        r_tag_pipe[i] <= '0;
      end
    end else begin
      r_tag_pipe[0] <= '{valid: tag_valid_in, first: tag_first_in, last: tag_last_in};
      for (int i = 1; i < TREE_LATENCY; i++) begin
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  assign w_dtag  = r_tag_pipe[TREE_LATENCY-1];
  assign w_sext  = {{(ACC_WIDTH-IN_WIDTH){sum_in[IN_WIDTH-1]}}, sum_in};
  assign w_total = w_dtag.first ? w_sext : r_acc + w_sext;
  assign w_push  = w_dtag.valid && w_dtag.last;

  // Round half up as floor(total / 2^s) plus bit s-1 of total; avoids a wide bias adder.
  always_comb begin
    w_half      = w_total;
    w_shifted   = w_total;
    w_round_bit = 1'b0;
    if (shift_in != '0) begin
      w_half      = w_total >>> (shift_in - 1'b1);
      w_shifted   = w_half >>> 1;
      w_round_bit = w_half[0];
    end
  end

  assign w_round    = w_shifted + {{(ACC_WIDTH-1){1'b0}}, w_round_bit};
  assign w_clamp_hi = (w_round > SatMax);
  assign w_clamp_lo = (w_round < SatMin);

  always_comb begin
    w_res = w_round[OUT_WIDTH-1:0];
    if (w_clamp_hi) begin
      w_res = SatMax[OUT_WIDTH-1:0];
    end else if (w_clamp_lo) begin
      w_res = SatMin[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_dtag.valid) begin
        r_acc <= w_total;
      end
      r_sat <= w_push && (w_clamp_hi || w_clamp_lo);
      r_ovf <= r_ovf || w_drop;
    end
  end

  psum_out_fifo #(
    .WIDTH (OUT_WIDTH)
  ) u_out_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .i_push    (w_push),
    .i_data    (w_res),
    .i_pop     (out_ready),
    .o_data    (w_out),
    .o_empty   (w_empty),
    .o_drop    (w_drop)
  );

  assign out          = w_out;
  assign out_valid    = !w_empty;
  assign sat_pulse    = r_sat;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed scenarios plus random beats checked against an
// arithmetic reference model of accumulate / round / saturate / 2-deep buffer.
module tb_psum_accumulator;

  localparam int L = 6;

  logic               clk = 1'b0;
  logic               arst_n_in;
  logic               tag_valid_in;
  logic               tag_first_in;
  logic               tag_last_in;
  logic signed [37:0] sum_in;
  logic [5:0]         shift_in;
  logic signed [15:0] out;
  logic               out_valid;
  logic               out_ready;
  logic               sat_pulse;
  logic               overflow_err;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .tag_valid_in (tag_valid_in),
    .tag_first_in (tag_first_in),
    .tag_last_in  (tag_last_in),
    .sum_in       (sum_in),
    .shift_in     (shift_in),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sat_pulse    (sat_pulse),
    .overflow_err (overflow_err)
  );

  typedef struct {
    bit     v;
    bit     f;
    bit     l;
    longint s;
  } beat_t;

  beat_t              pipe[$];
  longint             mq[$];
  longint             m_last;
  bit                 m_ovf;
  bit                 m_sat;
  logic signed [47:0] m_acc;
  int                 n_tests = 0;
  int                 n_fail  = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint requant(input longint total, input int s, output bit sat);
    longint r;
    r   = (total + ((s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0)) >>> s;
    sat = 1'b1;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    else sat = 1'b0;
    return r;
  endfunction

  task automatic clear_model();
    pipe.delete();
    repeat (L) pipe.push_back('{1'b0, 1'b0, 1'b0, 64'sd0});
    mq.delete();
    m_acc  = '0;
    m_last = 0;
    m_ovf  = 1'b0;
    m_sat  = 1'b0;
  endtask

  // One clock cycle: drive a tree-input beat, drive the tree output due this cycle,
  // advance the model at the edge and compare all outputs half a cycle later.
  task automatic step(input bit v, input bit f, input bit l, input longint s, input bit rdy);
    beat_t  d;
    bit     push;
    bit     pop;
    bit     sat;
    longint res;
    pipe.push_back('{v, f, l, s});
    d            = pipe.pop_front();
    tag_valid_in = v;
    tag_first_in = f;
    tag_last_in  = l;
    out_ready    = rdy;
    sum_in       = d.v ? 38'(d.s) : 38'($urandom);
    push         = 1'b0;
    sat          = 1'b0;
    res          = 0;
    if (arst_n_in && d.v) begin
      m_acc = d.f ? 48'(d.s) : m_acc + 48'(d.s);
      if (d.l) begin
        push = 1'b1;
        res  = requant(longint'(m_acc), int'(shift_in), sat);
      end
    end
    pop = arst_n_in && (mq.size() > 0) && rdy;
    @(posedge clk);
    if (!arst_n_in) begin
      clear_model();
    end else begin
      if (pop) m_last = mq.pop_front();
      if (push) begin
        if (mq.size() < 2) mq.push_back(res);
        else m_ovf = 1'b1;
      end
      m_sat = push && sat;
    end
    @(negedge clk);
    check("out_valid", out_valid, mq.size() > 0);
    check("out", out, (mq.size() > 0) ? mq[0] : m_last);
    check("sat_pulse", sat_pulse, m_sat);
    check("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0, rdy);
  endtask

  task automatic single(input string tag, input longint s, input longint exp, input bit exp_sat);
    step(1'b1, 1'b1, 1'b1, s, 1'b0);
    idle(L - 1, 1'b0);
    check({tag, "_early"}, out_valid, 1'b0);
    idle(1, 1'b0);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_out"}, out, exp);
    check({tag, "_sat"}, sat_pulse, exp_sat);
    idle(1, 1'b1);
  endtask

  initial begin
    bit open;
    bit v;
    bit f;
    bit l;
    longint s;
    arst_n_in    = 1'b0;
    tag_valid_in = 1'b0;
    tag_first_in = 1'b0;
    tag_last_in  = 1'b0;
    sum_in       = '0;
    shift_in     = 6'd0;
    out_ready    = 1'b0;
    clear_model();
    idle(2, 1'b0);
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 1'b0);
    arst_n_in = 1'b1;

    shift_in = 6'd2;
    single("t1", 1000, 250, 1'b0);

    shift_in = 6'd0;
    step(1'b1, 1'b1, 1'b0, 100, 1'b0);
    step(1'b1, 1'b0, 1'b0, -30, 1'b0);
    step(1'b1, 1'b0, 1'b0, 7, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3, 1'b0);
    idle(L - 1, 1'b0);
    check("t2_early", out_valid, 1'b0);
    idle(1, 1'b0);
    check("t2_out", out, 80);
    idle(1, 1'b1);
    check("t2_single", out_valid, 1'b0);

    shift_in = 6'd1;
    single("t3a", 5, 3, 1'b0);
    single("t3b", -5, -2, 1'b0);
    single("t3c", -6, -3, 1'b0);

    shift_in = 6'd0;
    single("t4a", 64'sd1 <<< 20, 32767, 1'b1);
    single("t4b", -(64'sd1 <<< 20), -32768, 1'b1);

    step(1'b1, 1'b1, 1'b1, 1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3, 1'b0);
    idle(L, 1'b0);
    check("t5_ovf", overflow_err, 1'b1);
    check("t5_valid", out_valid, 1'b1);
    check("t5_head", out, 1);
    idle(1, 1'b1);
    check("t5_second", out, 2);
    idle(1, 1'b1);
    check("t5_empty", out_valid, 1'b0);
    check("t5_hold", out, 2);
    check("t5_ovf_sticky", overflow_err, 1'b1);

    step(1'b1, 1'b1, 1'b0, 50, 1'b1);
    arst_n_in = 1'b0;
    step(1'b1, 1'b0, 1'b0, 60, 1'b1);
    check("t6_rst_valid", out_valid, 1'b0);
    step(1'b1, 1'b0, 1'b1, 70, 1'b1);
    check("t6_ovf_clr", overflow_err, 1'b0);
    arst_n_in = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      idle(1, 1'b1);
      check("t6_quiet", out_valid, 1'b0);
    end
    single("t6", 9, 9, 1'b0);

    open = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 64) == 0) shift_in = 6'($urandom_range(0, 20));
      v = ($urandom_range(0, 99) < 65);
      f = !open || ($urandom_range(0, 99) < 5);
      l = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 99) < 10) s = longint'($urandom_range(0, 32'h7FFF_FFFF)) - 64'sd1073741824;
      else s = longint'($urandom_range(0, 131071)) - 64'sd65536;
      if (v) open = !l;
      arst_n_in = ($urandom_range(0, 999) != 0);
      if (!arst_n_in) open = 1'b0;
      step(v, f, l, s, ($urandom_range(0, 99) < 75));
      arst_n_in = 1'b1;
    end
    idle(L + 4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
